template_match_engine: RTL and testbench
========================================

TEMPLATE_MATCH_ENGINE -- requirements
Module: template_match_engine

Interface
REQ-001 Parameter RES_ROW, default 127, row index used for the result write.
REQ-002 Parameter RES_COL, default 0, word-column index used for the result write.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ready_2_start  input  1  controller grants a set; high for whole set.
REQ-006 rd_valid  input  1  rd_data valid this cycle for the outstanding read.
REQ-007 rd_data  input  32  read word, endian-corrected, pixel k at bits [31-8k -: 8].
REQ-008 req  output  1  single-cycle request strobe.
REQ-009 rd_wr  output  1  0 = read, 1 = write; qualified by req.
REQ-010 row  output  7  requested row index.
REQ-011 col  output  7  requested word-column index.
REQ-012 tem_win  output  1  0 = template region, 1 = search-window region.
REQ-013 write_data  output  32  result word; qualified by req with rd_wr=1.
REQ-014 set_done  output  1  single-cycle pulse when set completes.

Function
REQ-015 Template SHALL be 8x8 pixels (8 rows x 2 words); search window 16x16 (16 rows x 4 words); pixels unsigned 8-bit.
REQ-016 States SHALL be IDLE, LOAD_TEM, LOAD_WIN, COMPUTE, WRITE_RES, DONE.
REQ-017 IDLE -> LOAD_TEM on ready_2_start high.
REQ-018 One read outstanding at most; next req SHALL issue the cycle after rd_valid (or first LOAD cycle); req SHALL not repeat while a read is pending.
REQ-019 LOAD_TEM SHALL read tem_win=0 in raster order row 0..7, col 0..1; LOAD_WIN SHALL read tem_win=1 row 0..15, col 0..3.
REQ-020 rd_valid with no read pending SHALL be ignored.
REQ-021 COMPUTE SHALL evaluate offsets dy,dx in 0..8 raster order (dy outer), SAD = sum |T(r,c) - W(r+dy,c+dx)| over 64 pixels, 4 pixels per cycle, 16 cycles per offset, 1296 cycles total.
REQ-022 SAD accumulator SHALL be 14 bits (max 16320), no saturation needed.
REQ-023 Best offset SHALL update only on strictly smaller SAD; ties keep earliest raster offset; initial min = 14'h3FFF.
REQ-024 WRITE_RES SHALL assert req=1, rd_wr=1, row=RES_ROW, col=RES_COL, tem_win=0 for one cycle, write_data = {dy[7:0], dx[7:0], 2'b00, min_sad[13:0]}.
REQ-025 DONE SHALL pulse set_done one cycle, then IDLE; next set requires ready_2_start again (may be continuous).
REQ-026 ready_2_start falling in any non-IDLE state SHALL abort to IDLE next cycle, no write, no set_done.
REQ-027 Outside an active request, row/col/tem_win/write_data SHALL hold last value; rd_wr SHALL be 0.

Reset
REQ-028 On rst_n low: state IDLE, req=0, rd_wr=0, row=0, col=0, tem_win=0, write_data=0, set_done=0, buffers and min/best registers cleared.
REQ-029 Reset mid-set SHALL discard all loaded pixels and partial results.

Configuration
REQ-030 Macro SAD_EARLY_TERM_EN defined: an offset SHALL abort once partial SAD >= current min, advancing to next offset next cycle; result identical to non-terminated run.
REQ-031 Macro undefined: every offset SHALL take exactly 16 cycles.

Structure
REQ-032 Shared package astro_pkg SHALL hold state enum, pixel_t (8-bit), TEM_DIM=8, WIN_DIM=16, OFF_DIM=9, result field positions.
REQ-033 Sub-module sad4 SHALL compute combinational sum of four |a-b| 8-bit differences (10-bit output).

Verification
REQ-034 Template all 0x10, window all 0x10 -> write_data 0x0000_0000 (dy=0, dx=0, SAD=0), set_done one cycle after write.
REQ-035 Window 0x00 except 8x8 patch equal to template at (r=3,c=5), template random -> write_data[31:16]=0x0305, SAD=0.
REQ-036 Template all 0xFF, window all 0x00 -> write_data 0x0000_3FC0 (SAD 16320).
REQ-037 Identical matches at (1,2) and (4,4) -> dy=1, dx=2 reported.
REQ-038 Drop ready_2_start during COMPUTE -> no write req, no set_done, IDLE; rst_n low during LOAD_WIN -> all outputs at reset values.
REQ-039 rd_valid delayed 0..5 random cycles per read -> exactly 80 reads in required order, same result; with SAD_EARLY_TERM_EN, COMPUTE cycles < 1296 on REQ-035 stimulus.

Source files
------------

// File: rtl/astro_pkg.sv
// Shared types and constants for the template match engine: FSM states,
// pixel type, block dimensions and result word field positions.
package astro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TEM,
    LOAD_WIN,
    COMPUTE,
    WRITE_RES,
    DONE
  } state_t;

  typedef logic [7:0] pixel_t;

  localparam int TEM_DIM     = 8;
  localparam int WIN_DIM     = 16;
  localparam int OFF_DIM     = 9;
  localparam int SAD_W       = 14;
  localparam int RES_DY_LSB  = 24;
  localparam int RES_DX_LSB  = 16;
  localparam int RES_SAD_LSB = 0;

  localparam logic [SAD_W-1:0] SAD_INIT = 14'h3FFF;

  function automatic logic [31:0] pack_result(input logic [3:0] dy,
                                              input logic [3:0] dx,
                                              input logic [SAD_W-1:0] sad);
    logic [31:0] w;
    w = '0;
    w[RES_DY_LSB +: 8]      = {4'h0, dy};
    w[RES_DX_LSB +: 8]      = {4'h0, dx};
    w[RES_SAD_LSB +: SAD_W] = sad;
    return w;
  endfunction

endpackage

// File: rtl/template_match_engine_sad4.sv
// Combinational sum of absolute differences over four packed 8-bit pixels
// (pixel k at bits [31-8k -: 8]).
module sad4
  import astro_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [9:0]  sum
);

  pixel_t diff [4];

  for (genvar k = 0; k < 4; k++) begin : g_abs
    pixel_t pa;
    pixel_t pb;
    assign pa      = a[31-8*k -: 8];
    assign pb      = b[31-8*k -: 8];
    assign diff[k] = (pa > pb) ? (pa - pb) : (pb - pa);
  end

  assign sum = 10'(diff[0]) + 10'(diff[1]) + 10'(diff[2]) + 10'(diff[3]);

endmodule

// File: rtl/template_match_engine.sv
// Loads an 8x8 template and 16x16 search window, finds the minimum-SAD offset
// and writes it back. Define SAD_EARLY_TERM_EN to cut offsets short once hopeless.
module template_match_engine
  import astro_pkg::*;
#(
  parameter int RES_ROW = 127,
  parameter int RES_COL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready_2_start,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        req,
  output logic        rd_wr,
  output logic [6:0]  row,
  output logic [6:0]  col,
  output logic        tem_win,
  output logic [31:0] write_data,
  output logic        set_done
);

  state_t state, state_n;
  logic        pending, pending_n;
  logic [5:0]  load_idx, load_idx_n, next_idx;
  logic        req_n, rd_wr_n, tem_win_n, set_done_n;
  logic [6:0]  row_n, col_n;
  logic [31:0] write_data_n;
  logic        accept;

  pixel_t tem_buf [TEM_DIM][TEM_DIM];
  pixel_t win_buf [WIN_DIM][WIN_DIM];

  logic [3:0]       off_dy, off_dx, step;
  logic [SAD_W-1:0] acc, min_sad, offset_total, min_next;
  logic [3:0]       best_dy, best_dx, best_dy_next, best_dx_next;
  logic [31:0]      tem_word, win_word;
  logic [9:0]       part;
  logic             upd, offset_end, last_offset;
  logic [2:0]       t_row, t_col;
  logic [3:0]       w_row, w_col;

  assign accept   = pending && rd_valid;
  assign next_idx = load_idx + 6'd1;

  // Each compute cycle covers half a template row against the current offset.
  assign t_row = step[3:1];
  assign t_col = {step[0], 2'b00};
  assign w_row = {1'b0, t_row} + off_dy;
  assign w_col = {1'b0, t_col} + off_dx;

  always_comb begin
    tem_word = '0;
    win_word = '0;
    for (int k = 0; k < 4; k++) begin
      tem_word[31-8*k -: 8] = tem_buf[t_row][t_col + 3'(k)];
      win_word[31-8*k -: 8] = win_buf[w_row][w_col + 4'(k)];
    end
  end

  sad4 u_sad4 (
    .a   (tem_word),
    .b   (win_word),
    .sum (part)
  );

  assign offset_total = acc + SAD_W'(part);
  assign upd          = (step == 4'd15) && (offset_total < min_sad);
  assign min_next     = upd ? offset_total : min_sad;
  assign best_dy_next = upd ? off_dy : best_dy;
  assign best_dx_next = upd ? off_dx : best_dx;
  assign last_offset  = (off_dy == 4'(OFF_DIM-1)) && (off_dx == 4'(OFF_DIM-1));

`ifdef SAD_EARLY_TERM_EN
  assign offset_end = (step == 4'd15) || (offset_total >= min_sad);
`else
  assign offset_end = (step == 4'd15);
`endif

  always_comb begin
    state_n      = state;
    pending_n    = pending;
    load_idx_n   = load_idx;
    req_n        = 1'b0;
    rd_wr_n      = 1'b0;
    row_n        = row;
    col_n        = col;
    tem_win_n    = tem_win;
    write_data_n = write_data;
    set_done_n   = 1'b0;
    if (state != IDLE && !ready_2_start) begin
      state_n   = IDLE;
      pending_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ready_2_start) begin
            state_n    = LOAD_TEM;
            load_idx_n = '0;
            req_n      = 1'b1;
            pending_n  = 1'b1;
            row_n      = '0;
            col_n      = '0;
            tem_win_n  = 1'b0;
          end
        end
        LOAD_TEM: begin
          if (accept) begin
            req_n     = 1'b1;
            pending_n = 1'b1;
            if (load_idx == 6'd15) begin
              state_n    = LOAD_WIN;
              load_idx_n = '0;
              row_n      = '0;
              col_n      = '0;
              tem_win_n  = 1'b1;
            end else begin
              load_idx_n = next_idx;
              row_n      = {4'b0, next_idx[3:1]};
              col_n      = {6'b0, next_idx[0]};
            end
          end
        end
        LOAD_WIN: begin
          if (accept) begin
            if (load_idx == 6'd63) begin
              state_n   = COMPUTE;
              pending_n = 1'b0;
            end else begin
              req_n      = 1'b1;
              pending_n  = 1'b1;
              load_idx_n = next_idx;
              row_n      = {3'b0, next_idx[5:2]};
              col_n      = {5'b0, next_idx[1:0]};
            end
          end
        end
        COMPUTE: begin
          if (offset_end && last_offset) begin
            state_n      = WRITE_RES;
            req_n        = 1'b1;
            rd_wr_n      = 1'b1;
            row_n        = 7'(RES_ROW);
            col_n        = 7'(RES_COL);
            tem_win_n    = 1'b0;
            write_data_n = pack_result(best_dy_next, best_dx_next, min_next);
          end
        end
        WRITE_RES: begin
          state_n    = DONE;
          set_done_n = 1'b1;
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= 1'b0;
      load_idx   <= '0;
      req        <= 1'b0;
      rd_wr      <= 1'b0;
      row        <= '0;
      col        <= '0;
      tem_win    <= 1'b0;
      write_data <= '0;
      set_done   <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      load_idx   <= load_idx_n;
      req        <= req_n;
      rd_wr      <= rd_wr_n;
      row        <= row_n;
      col        <= col_n;
      tem_win    <= tem_win_n;
      write_data <= write_data_n;
      set_done   <= set_done_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < TEM_DIM; r++)
        for (int c = 0; c < TEM_DIM; c++)
          tem_buf[r][c] <= '0;
      for (int r = 0; r < WIN_DIM; r++)
        for (int c = 0; c < WIN_DIM; c++)
          win_buf[r][c] <= '0;
    end else if (accept && ready_2_start) begin
      for (int k = 0; k < 4; k++) begin
        if (state == LOAD_TEM)
          tem_buf[load_idx[3:1]][{load_idx[0], 2'b00} + 3'(k)] <= rd_data[31-8*k -: 8];
        if (state == LOAD_WIN)
          win_buf[load_idx[5:2]][{load_idx[1:0], 2'b00} + 4'(k)] <= rd_data[31-8*k -: 8];
      end
    end
  end

  // Search registers restart at the top of every set so an aborted set leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      step    <= '0;
      off_dy  <= '0;
      off_dx  <= '0;
      min_sad <= '0;
      best_dy <= '0;
      best_dx <= '0;
    end else if (state == COMPUTE) begin
      min_sad <= min_next;
      best_dy <= best_dy_next;
      best_dx <= best_dx_next;
      if (offset_end) begin
        acc  <= '0;
        step <= '0;
        if (off_dx == 4'(OFF_DIM-1)) begin
          off_dx <= '0;
          off_dy <= off_dy + 4'd1;
        end else begin
          off_dx <= off_dx + 4'd1;
        end
      end else begin
        acc  <= offset_total;
        step <= step + 4'd1;
      end
    end else begin
      acc    <= '0;
      step   <= '0;
      off_dy <= '0;
      off_dx <= '0;
      if (state == LOAD_TEM) begin
        min_sad <= SAD_INIT;
        best_dy <= '0;
        best_dx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_template_match_engine.sv
// Self-checking bench for template_match_engine: memory responder with random
// read latency and a brute-force SAD search as the reference.
module tb_template_match_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready_2_start;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        req;
  logic        rd_wr;
  logic [6:0]  row;
  logic [6:0]  col;
  logic        tem_win;
  logic [31:0] write_data;
  logic        set_done;

  int checks = 0;
  int passed = 0;

  byte unsigned tem [8][8];
  byte unsigned win [16][16];

  logic [31:0] obs_wdata;
  int obs_nreads, obs_read_errs, obs_proto, obs_nwrites, obs_ndone, obs_done_gap, obs_compute;

  always #5 clk = ~clk;

  template_match_engine #(.RES_ROW(127), .RES_COL(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ready_2_start(ready_2_start),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .req          (req),
    .rd_wr        (rd_wr),
    .row          (row),
    .col          (col),
    .tem_win      (tem_win),
    .write_data   (write_data),
    .set_done     (set_done)
  );

  function automatic logic [31:0] mem_word(input logic tw, input int r, input int c);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      if (!tw && r < 8 && c < 2)        w[31-8*k -: 8] = tem[r][4*c+k];
      else if (tw && r < 16 && c < 4)   w[31-8*k -: 8] = win[r][4*c+k];
    end
    return w;
  endfunction

  // Exhaustive search over all 81 placements; first strictly-smallest wins.
  function automatic logic [31:0] model_result();
    int best, bdy, bdx, s, d;
    best = 'h3FFF; bdy = 0; bdx = 0;
    for (int dy = 0; dy < 9; dy++)
      for (int dx = 0; dx < 9; dx++) begin
        s = 0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            d = int'(tem[r][c]) - int'(win[r+dy][c+dx]);
            s += (d < 0) ? -d : d;
          end
        if (s < best) begin best = s; bdy = dy; bdx = dx; end
      end
    return {8'(bdy), 8'(bdx), 2'b00, 14'(best)};
  endfunction

  task automatic fill_random();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) tem[r][c] = 8'($urandom);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) win[r][c] = 8'($urandom);
  endtask

  task automatic fill_const(input byte unsigned tv, input byte unsigned wv);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) tem[r][c] = tv;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) win[r][c] = wv;
  endtask

  task automatic place_patch(input int py, input int px);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) win[py+r][px+c] = tem[r][c];
  endtask

  task automatic run_set(input int max_delay, input int drop_at, input int reset_at, input bit keep);
    int cyc, cnt, last_valid, write_cyc, stop_cyc, p_row, p_col, e_row, e_col, j;
    bit have_pend, served;
    logic p_tw, e_tw;
    cyc = 0; cnt = 0; last_valid = -1; write_cyc = -1; stop_cyc = -1;
    have_pend = 0; p_tw = 0; p_row = 0; p_col = 0;
    obs_wdata = '0; obs_nreads = 0; obs_read_errs = 0; obs_proto = 0;
    obs_nwrites = 0; obs_ndone = 0; obs_done_gap = -1; obs_compute = -1;
    ready_2_start = 1'b1;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      rd_valid = 1'b0;
      rd_data  = $urandom;
      served   = 0;
      if (have_pend) begin
        if (cnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem_word(p_tw, p_row, p_col);
          have_pend = 0; served = 1; last_valid = cyc;
        end else cnt--;
      end
      if (!req && rd_wr) obs_proto++;
      if (req && !rd_wr) begin
        if (have_pend || served) obs_proto++;
        else begin
          if (obs_nreads < 16) begin
            e_tw = 1'b0; e_row = obs_nreads / 2; e_col = obs_nreads % 2;
          end else begin
            j = obs_nreads - 16; e_tw = 1'b1; e_row = j / 4; e_col = j % 4;
          end
          if (obs_nreads >= 80 || tem_win !== e_tw || int'(row) != e_row || int'(col) != e_col)
            obs_read_errs++;
          obs_nreads++;
          have_pend = 1; cnt = $urandom_range(0, max_delay);
          p_tw = tem_win; p_row = int'(row); p_col = int'(col);
        end
      end
      if (req && rd_wr) begin
        obs_nwrites++; obs_wdata = write_data; write_cyc = cyc;
        obs_compute = cyc - last_valid - 1;
        if (row !== 7'd127 || col !== 7'd0 || tem_win !== 1'b0) obs_proto++;
      end
      if (set_done) begin
        obs_ndone++;
        if (write_cyc >= 0) obs_done_gap = cyc - write_cyc;
      end
      if (obs_nreads == 80 && !have_pend && !rd_valid && write_cyc < 0 && $urandom_range(0, 3) == 0) begin
        rd_valid = 1'b1;
        rd_data  = $urandom;
      end
      if (reset_at >= 0 && obs_nreads >= reset_at && have_pend) begin
        rst_n = 1'b0;
        break;
      end
      if (drop_at >= 0 && stop_cyc < 0 && obs_nreads == 80 && !have_pend && last_valid >= 0 &&
          cyc == last_valid + drop_at) begin
        ready_2_start = 1'b0;
        stop_cyc = cyc + 30;
      end
      if (stop_cyc >= 0 && cyc >= stop_cyc) break;
      if (set_done && drop_at < 0) break;
    end
    if (!keep) begin
      ready_2_start = 1'b0;
      rd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; ready_2_start = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req, rd_wr, row, col, tem_win, write_data, set_done} !== '0)
      $display("[TB] FAIL reset_outputs: got req=%b rd_wr=%b row=%0d col=%0d tw=%b wd=%h done=%b required all zero",
               req, rd_wr, row, col, tem_win, write_data, set_done);
    else passed++;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      rd_valid = 1'(i % 2);
      rd_data  = $urandom;
      @(negedge clk);
      if (req !== 1'b0 || set_done !== 1'b0) bad++;
    end
    rd_valid = 1'b0;
    checks++;
    if (bad != 0) $display("[TB] FAIL idle_quiet: got %0d active cycles required 0", bad);
    else passed++;
  endtask

  task automatic test_uniform();
    fill_const(8'h10, 8'h10);
    run_set(2, -1, -1, 0);
    checks++;
    if (obs_wdata !== 32'h0000_0000) $display("[TB] FAIL uniform_result: got %h required %h", obs_wdata, 32'h0);
    else passed++;
    checks++;
    if (obs_ndone != 1 || obs_done_gap != 1)
      $display("[TB] FAIL uniform_done: got %0d pulses gap %0d required 1 pulse gap 1", obs_ndone, obs_done_gap);
    else passed++;
    checks++;
    if (obs_nreads != 80 || obs_read_errs != 0 || obs_proto != 0)
      $display("[TB] FAIL uniform_reads: got %0d reads %0d misordered %0d protocol required 80/0/0",
               obs_nreads, obs_read_errs, obs_proto);
    else passed++;
  endtask

  task automatic test_patch();
    logic [31:0] exp;
    fill_const(8'h00, 8'h00);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) tem[r][c] = 8'($urandom_range(1, 255));
    place_patch(3, 5);
    exp = model_result();
    run_set(3, -1, -1, 0);
    checks++;
    if (obs_wdata[31:16] !== 16'h0305 || obs_wdata[13:0] !== 14'h0)
      $display("[TB] FAIL patch_offset: got %h required 0305 with zero sad", obs_wdata);
    else passed++;
    checks++;
    if (obs_wdata !== exp) $display("[TB] FAIL patch_model: got %h required %h", obs_wdata, exp);
    else passed++;
`ifdef SAD_EARLY_TERM_EN
    checks++;
    if (!(obs_compute > 0 && obs_compute < 1296))
      $display("[TB] FAIL patch_compute_cycles: got %0d required below 1296", obs_compute);
    else passed++;
`else
    checks++;
    if (obs_compute != 1296)
      $display("[TB] FAIL patch_compute_cycles: got %0d required 1296", obs_compute);
    else passed++;
`endif
  endtask

  task automatic test_max();
    fill_const(8'hFF, 8'h00);
    run_set(1, -1, -1, 0);
    checks++;
    if (obs_wdata !== 32'h0000_3FC0) $display("[TB] FAIL max_sad: got %h required %h", obs_wdata, 32'h0000_3FC0);
    else passed++;
  endtask

  task automatic test_tie();
    fill_const(8'h80, 8'h00);
    place_patch(1, 2);
    place_patch(4, 4);
    run_set(2, -1, -1, 0);
    checks++;
    if (obs_wdata !== 32'h0102_0000) $display("[TB] FAIL tie_earliest: got %h required %h", obs_wdata, 32'h0102_0000);
    else passed++;
  endtask

  task automatic test_random_delay();
    logic [31:0] exp;
    for (int it = 0; it < 2; it++) begin
      fill_random();
      if (it == 1) place_patch($urandom_range(0, 8), $urandom_range(0, 8));
      exp = model_result();
      run_set(5, -1, -1, 0);
      checks++;
      if (obs_wdata !== exp) $display("[TB] FAIL random_result_%0d: got %h required %h", it, obs_wdata, exp);
      else passed++;
      checks++;
      if (obs_nreads != 80 || obs_read_errs != 0 || obs_proto != 0 || obs_nwrites != 1)
        $display("[TB] FAIL random_reads_%0d: got %0d reads %0d misordered %0d protocol %0d writes required 80/0/0/1",
                 it, obs_nreads, obs_read_errs, obs_proto, obs_nwrites);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a, exp_b;
    fill_random();
    exp_a = model_result();
    run_set(2, -1, -1, 1);
    checks++;
    if (obs_wdata !== exp_a || obs_ndone != 1) $display("[TB] FAIL b2b_first: got %h required %h", obs_wdata, exp_a);
    else passed++;
    fill_const(8'h20, 8'h00);
    place_patch(7, 1);
    exp_b = model_result();
    run_set(2, -1, -1, 0);
    checks++;
    if (obs_wdata !== exp_b || obs_nreads != 80 || obs_read_errs != 0)
      $display("[TB] FAIL b2b_second: got %h with %0d reads required %h with 80 reads", obs_wdata, obs_nreads, exp_b);
    else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] exp;
    fill_random();
    run_set(2, 200, -1, 0);
    checks++;
    if (obs_nwrites != 0 || obs_ndone != 0 || obs_nreads != 80)
      $display("[TB] FAIL abort_compute: got %0d writes %0d done %0d reads required 0/0/80",
               obs_nwrites, obs_ndone, obs_nreads);
    else passed++;
    fill_random();
    exp = model_result();
    run_set(1, -1, -1, 0);
    checks++;
    if (obs_wdata !== exp) $display("[TB] FAIL abort_restart: got %h required %h", obs_wdata, exp);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] exp;
    fill_random();
    run_set(2, -1, 30, 0);
    #1;
    checks++;
    if ({req, rd_wr, row, col, tem_win, write_data, set_done} !== '0)
      $display("[TB] FAIL reset_mid_load: got req=%b rd_wr=%b row=%0d col=%0d tw=%b wd=%h done=%b required all zero",
               req, rd_wr, row, col, tem_win, write_data, set_done);
    else passed++;
    @(negedge clk);
    ready_2_start = 1'b0;
    rd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random();
    place_patch(8, 0);
    exp = model_result();
    run_set(3, -1, -1, 0);
    checks++;
    if (obs_wdata !== exp || obs_nreads != 80)
      $display("[TB] FAIL reset_restart: got %h with %0d reads required %h with 80 reads", obs_wdata, obs_nreads, exp);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_patch();
    test_max();
    test_tie();
    test_random_delay();
    test_back_to_back();
    test_abort();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
